// File: rtl/pe_mac_stream.sv
// Systolic MAC processing element: buffers W/I/O streams, forwards W and I to
// neighbouring PEs and runs a stall-able multiply-accumulate pipeline.

// Circular buffer with one write pointer and two independent read paths
// (neighbour forward and MAC). An entry is freed only once both paths consumed it.
module pe_stream_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             mac_valid,
    output logic [WIDTH-1:0] mac_data,
    input  logic             mac_take,
    output logic             pending
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] fwd_pend;
    logic [DEPTH-1:0] mac_pend;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] fwd_ptr;
    logic [PTR_W-1:0] mac_ptr;
    logic             wr_en;
    logic             fwd_en;
    logic             mac_en;

    // Entries fill and drain in order, so a free slot exists exactly when the
    // slot under wr_ptr is free; flags are registered, so no same-cycle bypass.
    assign in_rdy    = ~fwd_pend[wr_ptr] & ~mac_pend[wr_ptr];
    assign out_valid = fwd_pend[fwd_ptr];
    assign out_data  = mem[fwd_ptr];
    assign mac_valid = mac_pend[mac_ptr];
    assign mac_data  = mem[mac_ptr];
    assign pending   = |{fwd_pend, mac_pend};

    assign wr_en  = in_valid & in_rdy;
    assign fwd_en = out_valid & out_rdy;
    assign mac_en = mac_valid & mac_take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            fwd_pend <= '0;
            mac_pend <= '0;
            wr_ptr   <= '0;
            fwd_ptr  <= '0;
            mac_ptr  <= '0;
        end else begin
            if (fwd_en) begin
                fwd_pend[fwd_ptr] <= 1'b0;
                fwd_ptr           <= fwd_ptr + PTR_W'(1);
            end
            if (mac_en) begin
                mac_pend[mac_ptr] <= 1'b0;
                mac_ptr           <= mac_ptr + PTR_W'(1);
            end
            if (wr_en) begin
                mem[wr_ptr]      <= in_data;
                fwd_pend[wr_ptr] <= 1'b1;
                mac_pend[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
        end
    end
endmodule

// Handshake rule for every stream port: a transfer happens on a rising edge
// where valid & rdy are both high; a raised valid and its data stay stable
// until rdy is sampled high.
module pe_mac_stream #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 3,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              w_in_valid,
    output logic              w_in_rdy,
    input  logic [DATA_W-1:0] w_in,
    output logic              w_out_valid,
    input  logic              w_out_rdy,
    output logic [DATA_W-1:0] w_out,
    input  logic              i_in_valid,
    output logic              i_in_rdy,
    input  logic [DATA_W-1:0] i_in,
    output logic              i_out_valid,
    input  logic              i_out_rdy,
    output logic [DATA_W-1:0] i_out,
    input  logic              o_in_valid,
    output logic              o_in_rdy,
    input  logic [ACC_W-1:0]  o_in,
    output logic              o_out_valid,
    input  logic              o_out_rdy,
    output logic [ACC_W-1:0]  o_out,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NST   = MAC_LAT - 1;
    localparam logic [PTR_W:0] O_FULL = (PTR_W + 1)'(DEPTH);

    logic              w_mac_valid;
    logic              i_mac_valid;
    logic [DATA_W-1:0] w_mac;
    logic [DATA_W-1:0] i_mac;
    logic              w_pend;
    logic              i_pend;
    logic              issue;
    logic              adv;
    logic              mode_q;
    logic              mode_eff;
    logic              mode_free;

    logic [ACC_W-1:0]  o_mem [DEPTH];
    logic [PTR_W-1:0]  o_wr;
    logic [PTR_W-1:0]  o_rd;
    logic [PTR_W:0]    o_cnt;
    logic              o_empty;
    logic              o_push;
    logic              o_pop;

    logic signed [2*DATA_W-1:0] prod_full;
    logic [ACC_W-1:0]  prod;

    logic [NST-1:0]    st_v;
    logic [ACC_W-1:0]  st_p [NST];
    logic [ACC_W-1:0]  st_o [NST];
    logic              fin_v;
    logic [ACC_W-1:0]  fin_p;
    logic [ACC_W-1:0]  fin_o;

    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  acc_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_now;
    logic              grp_done;

    pe_stream_buf #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_w_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_rdy    (w_in_rdy),
        .in_data   (w_in),
        .out_valid (w_out_valid),
        .out_rdy   (w_out_rdy),
        .out_data  (w_out),
        .mac_valid (w_mac_valid),
        .mac_data  (w_mac),
        .mac_take  (issue),
        .pending   (w_pend)
    );

    pe_stream_buf #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_i_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (i_in_valid),
        .in_rdy    (i_in_rdy),
        .in_data   (i_in),
        .out_valid (i_out_valid),
        .out_rdy   (i_out_rdy),
        .out_data  (i_out),
        .mac_valid (i_mac_valid),
        .mac_data  (i_mac),
        .mac_take  (issue),
        .pending   (i_pend)
    );

    // Mode may only change once nothing of the previous mode is left anywhere.
    assign mode_free = ~|st_v & ~o_out_valid & (acc_cnt == '0) & o_empty;
    assign mode_eff  = mode_free ? mode : mode_q;

    assign adv   = ~(o_out_valid & ~o_out_rdy);
    assign issue = w_mac_valid & i_mac_valid & (mode_eff | ~o_empty) & adv;

    assign o_empty  = (o_cnt == '0);
    assign o_in_rdy = ~mode_eff & (o_cnt != O_FULL);
    assign o_push   = o_in_valid & o_in_rdy;
    assign o_pop    = issue & ~mode_eff;

    assign prod_full = $signed(w_mac) * $signed(i_mac);
    assign prod      = ACC_W'(prod_full);

    assign fin_v    = st_v[NST-1];
    assign fin_p    = st_p[NST-1];
    assign fin_o    = st_o[NST-1];
    assign len_now  = (acc_cnt != '0) ? len_q : ((acc_len == '0) ? LEN_W'(1) : acc_len);
    assign grp_done = ((acc_cnt + LEN_W'(1)) == len_now);

    assign busy = w_pend | i_pend | ~o_empty | (|st_v) | o_out_valid | (acc_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_eff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) o_mem[k] <= '0;
            o_wr  <= '0;
            o_rd  <= '0;
            o_cnt <= '0;
        end else begin
            if (o_push) begin
                o_mem[o_wr] <= o_in;
                o_wr        <= o_wr + PTR_W'(1);
            end
            if (o_pop) o_rd <= o_rd + PTR_W'(1);
            case ({o_push, o_pop})
                2'b10:   o_cnt <= o_cnt + (PTR_W + 1)'(1);
                2'b01:   o_cnt <= o_cnt - (PTR_W + 1)'(1);
                default: o_cnt <= o_cnt;
            endcase
        end
    end

    // Product is formed at issue; the partial-sum (0 in local-accumulate mode)
    // travels alongside it to the final stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_v <= '0;
            for (int k = 0; k < NST; k++) begin
                st_p[k] <= '0;
                st_o[k] <= '0;
            end
        end else if (adv) begin
            st_v[0] <= issue;
            st_p[0] <= prod;
            st_o[0] <= mode_eff ? '0 : o_mem[o_rd];
            for (int k = 1; k < NST; k++) begin
                st_v[k] <= st_v[k-1];
                st_p[k] <= st_p[k-1];
                st_o[k] <= st_o[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_out_valid <= 1'b0;
            o_out       <= '0;
            acc         <= '0;
            acc_cnt     <= '0;
            len_q       <= '0;
        end else if (adv) begin
            o_out_valid <= 1'b0;
            if (fin_v) begin
                if (!mode_q) begin
                    o_out_valid <= 1'b1;
                    o_out       <= fin_o + fin_p;
                end else if (grp_done) begin
                    o_out_valid <= 1'b1;
                    o_out       <= acc + fin_p;
                    acc         <= '0;
                    acc_cnt     <= '0;
                end else begin
                    acc     <= acc + fin_p;
                    acc_cnt <= acc_cnt + LEN_W'(1);
                    len_q   <= len_now;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream: vector table, directed corner-case
// sequences and randomized streams against a queue-based reference model.
module tb_pe_mac_stream;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int DEPTH   = 4;
    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mode = 1'b0;
    logic [LEN_W-1:0]  acc_len = '0;
    logic              w_in_valid = 1'b0, w_in_rdy, w_out_valid, w_out_rdy = 1'b1;
    logic [DATA_W-1:0] w_in = '0, w_out;
    logic              i_in_valid = 1'b0, i_in_rdy, i_out_valid, i_out_rdy = 1'b1;
    logic [DATA_W-1:0] i_in = '0, i_out;
    logic              o_in_valid = 1'b0, o_in_rdy, o_out_valid, o_out_rdy = 1'b1;
    logic [ACC_W-1:0]  o_in = '0, o_out;
    logic              busy;

    always #5 clk = ~clk;

    pe_mac_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .mode(mode), .acc_len(acc_len),
        .w_in_valid(w_in_valid), .w_in_rdy(w_in_rdy), .w_in(w_in),
        .w_out_valid(w_out_valid), .w_out_rdy(w_out_rdy), .w_out(w_out),
        .i_in_valid(i_in_valid), .i_in_rdy(i_in_rdy), .i_in(i_in),
        .i_out_valid(i_out_valid), .i_out_rdy(i_out_rdy), .i_out(i_out),
        .o_in_valid(o_in_valid), .o_in_rdy(o_in_rdy), .o_in(o_in),
        .o_out_valid(o_out_valid), .o_out_rdy(o_out_rdy), .o_out(o_out),
        .busy(busy)
    );

    typedef struct {
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] i;
        logic [ACC_W-1:0]  o;
        logic [ACC_W-1:0]  res;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int n_rcv = 0;
    logic [ACC_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] w_fwd_q[$], i_fwd_q[$];
    logic [DATA_W-1:0] w_src_q[$], i_src_q[$];
    logic [ACC_W-1:0]  o_src_q[$];
    int in_pct = 100;
    int out_pct = 100;
    bit w_out_hold = 0, i_out_hold = 0, o_out_hold = 0, chk_o_rdy_low = 0;
    bit w_fire = 0, i_fire = 0, o_fire = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference arithmetic: signed product reduced modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return ACC_W'(p);
    endfunction

    // Monitor: records input transfers and scores every output transfer.
    always @(negedge clk) begin
        if (reset) begin
            w_fire = w_in_valid & w_in_rdy;
            i_fire = i_in_valid & i_in_rdy;
            o_fire = o_in_valid & o_in_rdy;
            if (o_out_valid && o_out_rdy) begin
                n_rcv++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL o_out_extra: got %0h expected no result", o_out);
                end else check("o_out_seq", o_out, exp_q.pop_front());
            end
            if (w_out_valid && w_out_rdy) begin
                if (w_fwd_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL w_out_extra: got %0h expected no transfer", w_out);
                end else check("w_out_seq", w_out, w_fwd_q.pop_front());
            end
            if (i_out_valid && i_out_rdy) begin
                if (i_fwd_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL i_out_extra: got %0h expected no transfer", i_out);
                end else check("i_out_seq", i_out, i_fwd_q.pop_front());
            end
            if (chk_o_rdy_low) check("o_in_rdy_mode1", o_in_rdy, 0);
        end else begin
            w_fire = 0; i_fire = 0; o_fire = 0;
        end
    end

    // One clock of the stream drivers: retire accepted items, keep held valids, pick new ones.
    task automatic step();
        @(posedge clk);
        #1;
        if (w_fire) void'(w_src_q.pop_front());
        if (i_fire) void'(i_src_q.pop_front());
        if (o_fire) void'(o_src_q.pop_front());
        if (!(w_in_valid && !w_fire)) w_in_valid = (w_src_q.size() > 0) && ($urandom_range(99) < in_pct);
        if (!(i_in_valid && !i_fire)) i_in_valid = (i_src_q.size() > 0) && ($urandom_range(99) < in_pct);
        if (!(o_in_valid && !o_fire)) o_in_valid = (o_src_q.size() > 0) && ($urandom_range(99) < in_pct);
        if (w_src_q.size() > 0) w_in = w_src_q[0];
        if (i_src_q.size() > 0) i_in = i_src_q[0];
        if (o_src_q.size() > 0) o_in = o_src_q[0];
        w_out_rdy = !w_out_hold && ($urandom_range(99) < out_pct);
        i_out_rdy = !i_out_hold && ($urandom_range(99) < out_pct);
        o_out_rdy = !o_out_hold && ($urandom_range(99) < out_pct);
    endtask

    task automatic pump(input string name, input int max_cycles, input bit incl_fwd);
        int n = 0;
        while (n < max_cycles && (w_src_q.size() + i_src_q.size() + o_src_q.size() + exp_q.size()
               + (incl_fwd ? (w_fwd_q.size() + i_fwd_q.size()) : 0)) != 0) begin
            step();
            n++;
        end
        check({name, "_done"}, (n < max_cycles), 1);
    endtask

    task automatic push_mac(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] i,
                            input logic [ACC_W-1:0] o, input bit with_psum);
        w_src_q.push_back(w); i_src_q.push_back(i);
        w_fwd_q.push_back(w); i_fwd_q.push_back(i);
        if (with_psum) begin
            o_src_q.push_back(o);
            exp_q.push_back(o + mul(w, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[7];
        int rcv0;
        logic [ACC_W-1:0] held;
        tbl[0] = '{w: 8'h03, i: 8'hFC, o: 16'h0064, res: 16'h0058};
        tbl[1] = '{w: 8'h7F, i: 8'h7F, o: 16'h7FFF, res: 16'hBF00};
        tbl[2] = '{w: 8'h80, i: 8'h80, o: 16'h0000, res: 16'h4000};
        tbl[3] = '{w: 8'h80, i: 8'h7F, o: 16'h0000, res: 16'hC080};
        tbl[4] = '{w: 8'h00, i: 8'h37, o: 16'hFFFF, res: 16'hFFFF};
        tbl[5] = '{w: 8'hFF, i: 8'hFF, o: 16'hFFFF, res: 16'h0000};
        tbl[6] = '{w: 8'h0A, i: 8'h0A, o: 16'hFF9C, res: 16'h0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_w_in_rdy", w_in_rdy, 1);
        check("rst_i_in_rdy", i_in_rdy, 1);
        check("rst_o_in_rdy", o_in_rdy, 1);
        check("rst_w_out_valid", w_out_valid, 0);
        check("rst_i_out_valid", i_out_valid, 0);
        check("rst_o_out_valid", o_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_o_out", o_out, 0);
        check("rst_w_out", w_out, 0);

        // Vector table, mode 0: latency, value and forwarding of each vector
        for (int k = 0; k < 7; k++) begin
            push_mac(tbl[k].w, tbl[k].i, tbl[k].o, 1'b1);
            step();
            for (int c = 1; c <= MAC_LAT + 1; c++) begin
                step();
                if (c == 1) begin
                    check("tbl_w_out", w_out, tbl[k].w);
                    check("tbl_i_out", i_out, tbl[k].i);
                end
                if (c < MAC_LAT + 1) check("tbl_lat_early", o_out_valid, 0);
                else begin
                    check("tbl_lat_valid", o_out_valid, 1);
                    check("tbl_value", o_out, tbl[k].res);
                end
            end
            pump("tbl", 50, 1'b1);
        end
        step();
        check("tbl_idle_busy", busy, 0);

        // Neighbour stalls weight forwarding: MAC keeps going until the W buffer fills
        rcv0 = n_rcv;
        w_out_hold = 1;
        for (int k = 1; k <= 4; k++) push_mac(DATA_W'(k), DATA_W'($urandom), ACC_W'($urandom), 1'b1);
        pump("bp_mac", 100, 1'b0);
        check("bp_results", n_rcv - rcv0, 4);
        check("bp_w_in_rdy_full", w_in_rdy, 0);
        check("bp_w_out_head", w_out, 1);
        check("bp_busy", busy, 1);
        w_out_hold = 0;
        pump("bp_fwd", 100, 1'b1);
        check("bp_w_in_rdy_free", w_in_rdy, 1);

        // Mode 1, two groups of three products
        rcv0 = n_rcv;
        mode = 1'b1;
        acc_len = 8'd3;
        chk_o_rdy_low = 1;
        push_mac(8'd2, 8'd5, '0, 1'b0);
        push_mac(8'hFF, 8'd7, '0, 1'b0);
        push_mac(8'd4, 8'd4, '0, 1'b0);
        exp_q.push_back(16'd19);
        push_mac(8'd1, 8'd1, '0, 1'b0);
        push_mac(8'd2, 8'd2, '0, 1'b0);
        push_mac(8'd3, 8'd3, '0, 1'b0);
        exp_q.push_back(16'd14);
        pump("m1", 200, 1'b1);
        check("m1_results", n_rcv - rcv0, 2);
        chk_o_rdy_low = 0;
        mode = 1'b0;
        step();

        // Output stall mid-burst: value frozen, nothing lost or duplicated
        rcv0 = n_rcv;
        for (int k = 0; k < 6; k++) push_mac(DATA_W'($urandom), DATA_W'($urandom), ACC_W'($urandom), 1'b1);
        for (int n = 0; n < 50 && (n_rcv - rcv0) < 2; n++) step();
        o_out_hold = 1;
        step();
        held = o_out;
        check("stall_valid", o_out_valid, 1);
        for (int n = 0; n < 4; n++) begin
            step();
            check("stall_valid", o_out_valid, 1);
            check("stall_frozen", o_out, held);
        end
        o_out_hold = 0;
        pump("stall", 100, 1'b1);
        check("stall_results", n_rcv - rcv0, 6);

        // Twelve sequential entries through the circular buffers
        rcv0 = n_rcv;
        for (int k = 1; k <= 12; k++) push_mac(DATA_W'(k), DATA_W'(k + 1), ACC_W'(k * 100), 1'b1);
        pump("wrap", 200, 1'b1);
        check("wrap_results", n_rcv - rcv0, 12);

        // Randomized mode 0 with random valids and back-pressure
        in_pct = 60;
        out_pct = 70;
        for (int k = 0; k < 40; k++) push_mac(DATA_W'($urandom), DATA_W'($urandom), ACC_W'($urandom), 1'b1);
        pump("rand_m0", 2000, 1'b1);

        // Randomized mode 1 groups, including acc_len = 0 (one product per result)
        mode = 1'b1;
        for (int g = 0; g < 6; g++) begin
            int len;
            logic [ACC_W-1:0] sum;
            len = $urandom_range(4);
            acc_len = LEN_W'(len);
            if (len == 0) len = 1;
            sum = '0;
            for (int k = 0; k < len; k++) begin
                logic [DATA_W-1:0] a, b;
                a = DATA_W'($urandom);
                b = DATA_W'($urandom);
                push_mac(a, b, '0, 1'b0);
                sum = sum + mul(a, b);
            end
            exp_q.push_back(sum);
            pump("rand_m1", 500, 1'b1);
        end
        mode = 1'b0;
        in_pct = 100;
        out_pct = 100;
        repeat (2) step();
        check("final_busy", busy, 0);

        // Reset with three entries parked in the W and I buffers
        w_out_hold = 1;
        i_out_hold = 1;
        for (int k = 0; k < 3; k++) begin
            w_src_q.push_back(DATA_W'(k + 7));
            i_src_q.push_back(DATA_W'(k + 9));
        end
        pump("mid_fill", 50, 1'b0);
        check("mid_busy", busy, 1);
        check("mid_w_in_rdy", w_in_rdy, 1);
        reset = 1'b0;
        w_in_valid = 1'b0;
        i_in_valid = 1'b0;
        o_in_valid = 1'b0;
        #2;
        check("mid_rst_w_out_valid", w_out_valid, 0);
        check("mid_rst_busy", busy, 0);
        step();
        #1 reset = 1'b1;
        w_out_hold = 0;
        i_out_hold = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            check("post_rst_o_valid", o_out_valid, 0);
            check("post_rst_w_valid", w_out_valid, 0);
            check("post_rst_i_valid", i_out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
